// File: rtl/branch_ckpt_pkg.sv
// branch_ckpt_pkg: shared defaults and FSM encoding for the branch checkpoint controller.
package branch_ckpt_pkg;
    localparam int NCKPT_DEF     = 8;
    localparam int TAG_W_DEF     = $clog2(NCKPT_DEF);
    localparam int DRAIN_CYC_DEF = 2;
    typedef enum logic [1:0] {IDLE, RECOVER, DRAIN} ckpt_state_e;
endpackage

// File: rtl/ckpt_age_mask.sv
// ckpt_age_mask: marks every valid slot from start tag up to tail-1, wrapping modulo the slot count.
module ckpt_age_mask #(
    parameter int NCKPT = 8,
    parameter int TAG_W = $clog2(NCKPT)
) (
    input  logic [TAG_W-1:0] i_start_tag,
    input  logic [TAG_W-1:0] i_tail,
    input  logic [NCKPT-1:0] i_valid,
    output logic [NCKPT-1:0] o_mask
);
    // measuring to tail-1 keeps a full ring (start == tail) selecting every slot
    logic [TAG_W-1:0] w_lim;
    assign w_lim = i_tail - i_start_tag - TAG_W'(1);
    for (genvar k = 0; k < NCKPT; k++) begin : g_bit
        logic [TAG_W-1:0] w_dist;
        assign w_dist    = TAG_W'(k) - i_start_tag;
        assign o_mask[k] = i_valid[k] & (w_dist <= w_lim);
    end
endmodule

// File: rtl/branch_ckpt_ctrl.sv
// branch_ckpt_ctrl: allocates, resolves and retires rename checkpoints in program order
// and sequences mispredict recovery (restore pulse, flush mask, drain window).
module branch_ckpt_ctrl
    import branch_ckpt_pkg::*;
#(
    parameter int NCKPT     = NCKPT_DEF,
    parameter int TAG_W     = $clog2(NCKPT),
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    output logic             alloc_gnt,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             copy_en,
    output logic [TAG_W-1:0] copy_tag,
    output logic             fe_stall,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [TAG_W-1:0] res_tag,
    input  logic             res_mispredict,
    output logic             restore_en,
    output logic [TAG_W-1:0] restore_tag,
    output logic [NCKPT-1:0] flush_mask,
    output logic             free_en,
    output logic [TAG_W-1:0] free_tag,
    output logic [TAG_W:0]   busy_cnt
);
    localparam int DW = $clog2(DRAIN_CYC + 1);
    localparam logic [TAG_W:0] FULL = (TAG_W+1)'(NCKPT);

    ckpt_state_e      r_state, w_state_nxt;
    logic [TAG_W-1:0] r_head, r_tail, r_restore_tag, r_free_tag;
    logic [TAG_W:0]   r_count;
    logic [NCKPT-1:0] r_valid, r_resolved, r_flush_mask, w_valid_nxt, w_res_nxt, w_mask;
    logic [DW-1:0]    r_drain;
    logic             r_free_en;
    logic             w_idle, w_hit, w_mis, w_res_ok, w_gnt, w_retire;

    assign w_idle   = (r_state == IDLE);
    assign w_hit    = res_valid & w_idle & r_valid[res_tag];
    assign w_mis    = w_hit & res_mispredict;
    assign w_res_ok = w_hit & ~res_mispredict;
    assign w_gnt    = alloc_req & w_idle & (r_count < FULL) & ~(res_valid & res_mispredict);
    assign w_retire = w_idle & r_valid[r_head] & r_resolved[r_head] & ~w_mis;

    ckpt_age_mask #(.NCKPT(NCKPT), .TAG_W(TAG_W)) u_mask (
        .i_start_tag (res_tag),
        .i_tail      (r_tail),
        .i_valid     (r_valid),
        .o_mask      (w_mask)
    );

    always_comb begin
        w_valid_nxt = r_valid;
        w_res_nxt   = r_resolved;
        if (w_gnt) begin
            w_valid_nxt[r_tail] = 1'b1;
            w_res_nxt[r_tail]   = 1'b0;
        end
        if (w_retire) w_valid_nxt[r_head] = 1'b0;
        if (w_res_ok) w_res_nxt[res_tag] = 1'b1;
        if (w_mis) begin
            w_valid_nxt = r_valid & ~w_mask;
            w_res_nxt   = r_resolved & ~w_mask;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_mis ? RECOVER : IDLE;
            RECOVER: w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = (r_drain == '0) ? IDLE : DRAIN;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_valid       <= '0;
            r_resolved    <= '0;
            r_drain       <= '0;
            r_restore_tag <= '0;
            r_flush_mask  <= '0;
            r_free_en     <= 1'b0;
            r_free_tag    <= '0;
        end else begin
            r_valid      <= w_valid_nxt;
            r_resolved   <= w_res_nxt;
            r_free_en    <= w_retire;
            r_flush_mask <= w_mis ? w_mask : '0;
            if (w_retire) r_free_tag <= r_head;
            if (r_state == RECOVER) r_drain <= DW'(DRAIN_CYC - 1);
            else if (r_state == DRAIN && r_drain != '0) r_drain <= r_drain - DW'(1);
            if (w_mis) begin
                r_restore_tag <= res_tag;
                r_tail        <= res_tag;
                r_count       <= {1'b0, res_tag - r_head};
            end else begin
                if (w_gnt) r_tail <= r_tail + TAG_W'(1);
                if (w_retire) r_head <= r_head + TAG_W'(1);
                r_count <= r_count + {{TAG_W{1'b0}}, w_gnt} - {{TAG_W{1'b0}}, w_retire};
            end
        end
    end

    assign alloc_gnt   = w_gnt;
    assign alloc_tag   = r_tail;
    assign copy_en     = w_gnt;
    assign copy_tag    = r_tail;
    assign fe_stall    = (r_count == FULL) | ~w_idle;
    assign res_ready   = w_idle;
    assign restore_en  = (r_state == RECOVER);
    assign restore_tag = r_restore_tag;
    assign flush_mask  = r_flush_mask;
    assign free_en     = r_free_en;
    assign free_tag    = r_free_tag;
    assign busy_cnt    = r_count;
endmodule

// File: doc/branch_ckpt_ctrl.md
# branch_ckpt_ctrl

Allocates, tracks and retires rename-checkpoint slots for in-flight branches and jumps in the out-of-order core. Sits between decode/rename, the RAT checkpoint store and the branch execution unit. Grants a checkpoint tag per decoded control-flow instruction, orders resolutions, and sequences misprediction recovery. Recovery consists of a RAT restore pulse, a younger-tag flush mask and a fixed drain window.

## Interface
- NCKPT, 8: checkpoint slots, power of two, ≥2
- TAG_W, $clog2(NCKPT): tag width
- DRAIN_CYC, 2: cycles held in DRAIN after restore, ≥1
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alloc_req  in  1  decoded branch/JAL/JALR needs a checkpoint
- alloc_gnt  out  1  checkpoint granted this cycle (combinational)
- alloc_tag  out  TAG_W  granted tag (= tail)
- copy_en  out  1  snapshot RAT into slot copy_tag; equals alloc_gnt
- copy_tag  out  TAG_W  = alloc_tag
- fe_stall  out  1  full or state≠IDLE
- res_valid  in  1  branch unit presents a resolution
- res_ready  out  1  state==IDLE (combinational)
- res_tag  in  TAG_W  resolved checkpoint
- res_mispredict  in  1  1 = redirect required
- restore_en  out  1  registered pulse: copy slot restore_tag back into RAT/freelist
- restore_tag  out  TAG_W  slot to restore
- flush_mask  out  NCKPT  slots killed (restore_tag and all younger), valid with restore_en
- free_en  out  1  oldest slot retired this cycle
- free_tag  out  TAG_W  retired slot
- busy_cnt  out  TAG_W+1  live slots

## Operation
- State: head, tail (TAG_W, wrap modulo NCKPT), count (0..NCKPT), valid[NCKPT], resolved[NCKPT]; FSM IDLE, RECOVER, DRAIN.
- Reset: head=tail=count=0, valid=resolved=0, state=IDLE; restore_en=0, flush_mask=0, free_en=0, restore_tag=0, free_tag=0, busy_cnt=0; fe_stall=0, res_ready=1 after reset.
- Allocate: alloc_gnt = alloc_req & state==IDLE & count<NCKPT & !(res_valid & res_mispredict). On grant: valid[tail]=1, resolved[tail]=0, tail++, count++.
- Resolve handshake: accepted when res_valid & res_ready. Tag with valid=0 ignored (no state change). Source holds res_valid/res_tag/res_mispredict until accepted.
- Correct resolve: resolved[res_tag]=1.
- Retire: in IDLE, if valid[head]&resolved[head]: free_en=1, free_tag=head (registered), clear valid, head++, count--. One slot per cycle. Resolve of head and retire of head may not coincide; retire sees resolved one cycle later.
- Mispredict (IDLE→RECOVER): restore_tag=res_tag; flush_mask bit k set for every valid k from res_tag to tail−1 modulo NCKPT; clear those valid/resolved; tail=res_tag; count=(res_tag−head) mod NCKPT. No alloc, no retire that cycle.
- RECOVER (1 cycle): restore_en=1 with mask; →DRAIN.
- DRAIN: counter DRAIN_CYC down to 0, then →IDLE. No alloc, no resolve, no retire.
- Alloc+retire same cycle: count unchanged. Mispredict on head slot: count→0, head unchanged.

## Timing
- alloc_gnt/copy_en: same cycle as alloc_req; tag visible same cycle.
- Mispredict accepted cycle T: restore_en, flush_mask, restore_tag high exactly at T+1 (one cycle); state IDLE, alloc_gnt possible, at T+2+DRAIN_CYC.
- free_en: one-cycle pulse, cycle after retirement condition sampled.
- Full (count==NCKPT): fe_stall=1, alloc_gnt=0; a retire frees a slot for the following cycle's grant.
- rst mid-RECOVER/DRAIN: all state and outputs to reset values next edge; no restore_en pulse.

## Structure
- Package branch_ckpt_pkg: NCKPT default, TAG_W, DRAIN_CYC default, state enum ckpt_state_e {IDLE, RECOVER, DRAIN}.
- Sub-module ckpt_age_mask: combinational, from (start_tag, tail, valid) produce NCKPT-bit wrap-aware mask; used for flush_mask.

## Test plan
- NCKPT=4: 4 consecutive alloc_req → tags 0,1,2,3, busy_cnt=4, fifth req: alloc_gnt=0, fe_stall=1.
- Full; resolve tag 0 correct → free_en with free_tag=0 next cycle, following cycle alloc grants tag 0.
- Tags 0..3 live, resolve tag 1 mispredict → next cycle restore_en=1, restore_tag=1, flush_mask=4'b1110, busy_cnt=1, next alloc after drain gets tag 1.
- Wrap: head=3, tail=2 (tags 3,0,1 live), mispredict tag 0 → flush_mask=4'b0011, tail=0, busy_cnt=1.
- Same cycle alloc_req and mispredict → alloc_gnt=0; res_valid during DRAIN held with res_ready=0 until IDLE, then accepted.
- rst asserted during DRAIN → busy_cnt=0, restore_en=0, res_ready=1, first alloc gets tag 0.
